// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// and loads the IF/ID register while absorbing stalls, memory latency and redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_ins,
  output logic        if_fire,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_ins,
  output logic        fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        id_valid_q, id_valid_d;
  logic        fetch_err_q, fetch_err_d;

  logic pc_ok, redirect;

  assign pc_ok    = (pc_q[1:0] == 2'b00) && (pc_q <= MAX_INSADDR);
  assign redirect = id_redirect && !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_ins_d    = id_ins_q;
    hold_d      = hold_q;
    drop_addr_d = drop_addr_q;
    fetch_err_d = fetch_err_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    if_ins      = 32'h0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = pc_ok;
        if_ins   = imem_rdata;
        if (redirect) begin
          pc_d       = npc;
          id_valid_d = 1'b0;
          id_pc_d    = 32'h0;
          id_ins_d   = 32'h0;
          // Request still in flight: remember its address so it stays stable until it lands.
          if (!imem_ready) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (!pc_ok) begin
          state_d     = ERR;
          fetch_err_d = 1'b1;
        end else if (imem_ready && !stall) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          id_ins_d   = imem_rdata;
          pc_d       = npc;
        end else if (imem_ready) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          id_valid_d = 1'b0;
          id_pc_d    = 32'h0;
          id_ins_d   = 32'h0;
        end
      end
      HOLD: begin
        if_ins = hold_q;
        if (redirect) begin
          pc_d       = npc;
          id_valid_d = 1'b0;
          id_pc_d    = 32'h0;
          id_ins_d   = 32'h0;
          state_d    = REQ;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          id_ins_d   = hold_q;
          pc_d       = npc;
          state_d    = REQ;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (redirect)   pc_d    = npc;
        if (imem_ready) state_d = REQ;
        if (!stall) begin
          id_valid_d = 1'b0;
          id_pc_d    = 32'h0;
          id_ins_d   = 32'h0;
        end
      end
      ERR: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0;
      id_ins_q    <= 32'h0;
      hold_q      <= 32'h0;
      drop_addr_q <= 32'h0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_ins_q    <= id_ins_d;
      hold_q      <= hold_d;
      drop_addr_q <= drop_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign if_fire   = !stall && !id_redirect &&
                     (((state_q == REQ) && imem_ready && pc_ok) || (state_q == HOLD));
  assign pc        = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_ins    = id_ins_q;
  assign fetch_err = fetch_err_q;

endmodule
